// File: rtl/sdf_r22_stage.sv
// Radix-2^2 single-path delay-feedback butterfly stage (BF2I / BF2II).
// Optional macro SDF_R22_SCALE_EN: halve sums/differences (floor) to avoid growth.
module sdf_r22_stage #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    output logic             out_sop,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im
);

    localparam int PB = $clog2(DEPTH);
    localparam int CW = $clog2(4 * DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CMAX =
        CW'((MODE == 1) ? (4 * DEPTH - 1) : (2 * DEPTH - 1));
    localparam logic [CW-1:0] CSOP  = CW'(DEPTH);
    localparam logic [PW-1:0] PFULL = PW'(DEPTH);

    function automatic logic [WIDTH-1:0] add_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
`ifdef SDF_R22_SCALE_EN
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        return WIDTH'(s >> 1);
`else
        return a + b;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] sub_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
`ifdef SDF_R22_SCALE_EN
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        return WIDTH'(s >> 1);
`else
        return a - b;
`endif
    endfunction

    logic [CW-1:0]    c_q;
    logic [CW-1:0]    c_d;
    logic [CW-1:0]    c_use;
    logic [PW-1:0]    prime_q;
    logic [PW-1:0]    prime_d;
    logic             primed;
    logic             phase;
    logic             rot;

    logic [WIDTH-1:0] dre_q [DEPTH];
    logic [WIDTH-1:0] dim_q [DEPTH];
    logic [WIDTH-1:0] d_re;
    logic [WIDTH-1:0] d_im;
    logic [WIDTH-1:0] wr_re;
    logic [WIDTH-1:0] wr_im;
    logic [WIDTH-1:0] sel_re;
    logic [WIDTH-1:0] sel_im;

    logic [WIDTH-1:0] ore_q;
    logic [WIDTH-1:0] oim_q;
    logic             ov_q;
    logic             os_q;

    assign d_re = dre_q[DEPTH-1];
    assign d_im = dim_q[DEPTH-1];

    // Counter position, phase, rotation decision and butterfly datapath
    always_comb begin
        c_use   = in_sop ? '0 : c_q;
        phase   = c_use[PB];
        rot     = (MODE == 1) && (c_use < CSOP);
        primed  = (prime_q == PFULL);
        c_d     = (c_use == CMAX) ? '0 : c_use + CW'(1);
        prime_d = primed ? prime_q : prime_q + PW'(1);
        wr_re   = in_re;
        wr_im   = in_im;
        sel_re  = d_re;
        sel_im  = d_im;
        if (phase) begin
            wr_re  = sub_f(d_re, in_re);
            wr_im  = sub_f(d_im, in_im);
            sel_re = add_f(d_re, in_re);
            sel_im = add_f(d_im, in_im);
        end else if (rot) begin
            sel_re = d_im;
            sel_im = (~d_re) + WIDTH'(1);
        end
    end

    // Sample counter and priming count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            prime_q <= '0;
        end else if (clr) begin
            c_q     <= '0;
            prime_q <= '0;
        end else if (in_valid) begin
            c_q     <= c_d;
            prime_q <= prime_d;
        end
    end

    // Feedback delay line, shifts only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dre_q[i] <= '0;
                dim_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                dre_q[i] <= '0;
                dim_q[i] <= '0;
            end
        end else if (in_valid) begin
            dre_q[0] <= wr_re;
            dim_q[0] <= wr_im;
            for (int i = 1; i < DEPTH; i++) begin
                dre_q[i] <= dre_q[i-1];
                dim_q[i] <= dim_q[i-1];
            end
        end
    end

    // Output register; data holds whenever no sample is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ore_q <= '0;
            oim_q <= '0;
            ov_q  <= 1'b0;
            os_q  <= 1'b0;
        end else if (clr) begin
            ov_q  <= 1'b0;
            os_q  <= 1'b0;
        end else if (in_valid) begin
            ore_q <= sel_re;
            oim_q <= sel_im;
            ov_q  <= primed;
            os_q  <= primed && (c_use == CSOP);
        end else begin
            ov_q  <= 1'b0;
            os_q  <= 1'b0;
        end
    end

    assign out_re    = ore_q;
    assign out_im    = oim_q;
    assign out_valid = ov_q;
    assign out_sop   = os_q;

endmodule

// File: tb/tb_sdf_r22_stage.sv
// Directed bench for sdf_r22_stage: BF2I (DEPTH 2) and BF2II (DEPTH 1).
// Build with or without SDF_R22_SCALE_EN; expectations follow the macro.
module tb_sdf_r22_stage;

    typedef struct {
        bit          sel;
        bit          v;
        bit          sop;
        bit          clr;
        logic [16:0] re;
        logic [16:0] im;
        bit          ev;
        bit          es;
        bit          cd;
        logic [16:0] er;
        logic [16:0] ei;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clr0, clr1;
    logic        vld0, vld1;
    logic        sop0, sop1;
    logic [16:0] re0, im0, re1, im1;
    logic        ov0, os0, ov1, os1;
    logic [16:0] ore0, oim0, ore1, oim1;

    int checks;
    int failures;

    vec_t tbl[$];

    sdf_r22_stage #(.WIDTH(17), .DEPTH(2), .MODE(0)) u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr0),
        .in_valid (vld0),
        .in_sop   (sop0),
        .in_re    (re0),
        .in_im    (im0),
        .out_valid(ov0),
        .out_sop  (os0),
        .out_re   (ore0),
        .out_im   (oim0)
    );

    sdf_r22_stage #(.WIDTH(17), .DEPTH(1), .MODE(1)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr1),
        .in_valid (vld1),
        .in_sop   (sop1),
        .in_re    (re1),
        .in_im    (im1),
        .out_valid(ov1),
        .out_sop  (os1),
        .out_re   (ore1),
        .out_im   (oim1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // exact butterfly result v -> stored/output 17-bit pattern
    function automatic logic [16:0] hs(input int v);
        int t;
`ifdef SDF_R22_SCALE_EN
        t = v >>> 1;
`else
        t = v;
`endif
        return t[16:0];
    endfunction

    function automatic vec_t mk(
        input bit sel, input bit v, input bit sop, input bit c,
        input int re, input int im,
        input bit ev, input bit es, input bit cd,
        input int er, input int ei
    );
        vec_t r;
        r.sel = sel;
        r.v   = v;
        r.sop = sop;
        r.clr = c;
        r.re  = 17'(re);
        r.im  = 17'(im);
        r.ev  = ev;
        r.es  = es;
        r.cd  = cd;
        r.er  = 17'(er);
        r.ei  = 17'(ei);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [16:0] act,
                       input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t r, input int idx);
        @(negedge clk);
        vld0 = !r.sel && r.v;
        sop0 = !r.sel && r.sop;
        clr0 = !r.sel && r.clr;
        re0  = r.sel ? 17'd0 : r.re;
        im0  = r.sel ? 17'd0 : r.im;
        vld1 = r.sel && r.v;
        sop1 = r.sel && r.sop;
        clr1 = r.sel && r.clr;
        re1  = r.sel ? r.re : 17'd0;
        im1  = r.sel ? r.im : 17'd0;
        @(posedge clk);
        #1;
        if (!r.sel) begin
            chk($sformatf("row%0d_valid", idx), 17'(ov0), 17'(r.ev));
            chk($sformatf("row%0d_sop", idx), 17'(os0), 17'(r.es));
            if (r.cd) begin
                chk($sformatf("row%0d_re", idx), ore0, r.er);
                chk($sformatf("row%0d_im", idx), oim0, r.ei);
            end
        end else begin
            chk($sformatf("row%0d_valid", idx), 17'(ov1), 17'(r.ev));
            chk($sformatf("row%0d_sop", idx), 17'(os1), 17'(r.es));
            if (r.cd) begin
                chk($sformatf("row%0d_re", idx), ore1, r.er);
                chk($sformatf("row%0d_im", idx), oim1, r.ei);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        clr0 = 0; clr1 = 0; vld0 = 0; vld1 = 0;
        sop0 = 0; sop1 = 0;
        re0 = 0; im0 = 0; re1 = 0; im1 = 0;

        // basic frame 1,2,3,4,0,0
        tbl.push_back(mk(0,1,1,0, 1,0,  0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 2,0,  0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 3,0,  1,1,1, hs(4),0));
        tbl.push_back(mk(0,1,0,0, 4,0,  1,0,1, hs(6),0));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),0));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,1, hs(-2),0));
        // clr, then same frame with input gaps
        tbl.push_back(mk(0,0,0,1, 0,0,  0,0,0, 0,0));
        tbl.push_back(mk(0,1,1,0, 1,0,  0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 2,0,  0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 3,0,  1,1,1, hs(4),0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,1, hs(4),0));
        tbl.push_back(mk(0,0,0,0, 77,77, 0,0,1, hs(4),0));
        tbl.push_back(mk(0,1,0,0, 4,0,  1,0,1, hs(6),0));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),0));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),0));
        // mid-frame resync, then clr with a valid input at c=3
        tbl.push_back(mk(0,1,1,0, 1,0,  1,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 2,0,  1,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 3,0,  1,1,1, hs(4),0));
        tbl.push_back(mk(0,1,0,1, 99,99, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 5,1,  0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 6,-2, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 7,3,  1,1,1, hs(12),hs(4)));
        tbl.push_back(mk(0,1,0,0, 8,4,  1,0,1, hs(14),hs(2)));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),hs(-2)));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, hs(-2),hs(-6)));
        // wrap: d = x = 65535
        tbl.push_back(mk(0,1,1,0, 65535,0, 1,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,  1,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 65535,0, 1,1,1, hs(131070),0));
        // BF2II, DEPTH 1
        tbl.push_back(mk(1,1,0,0, 10,0, 0,0,0, 0,0));
        tbl.push_back(mk(1,1,0,0, 20,0, 1,1,1, hs(30),0));
        tbl.push_back(mk(1,1,0,0, 30,0, 1,0,1, hs(-10),0));
        tbl.push_back(mk(1,1,0,0, 40,0, 1,0,1, hs(70),0));
        tbl.push_back(mk(1,1,0,0, 0,0,  1,0,1, 0,hs(10)));
        tbl.push_back(mk(1,1,0,0, 0,0,  1,1,1, 0,0));
        tbl.push_back(mk(1,1,0,0, -1,0, 1,0,1, 0,0));
        tbl.push_back(mk(1,1,0,0, 65535,0, 1,0,1, hs(65534),0));
        tbl.push_back(mk(1,1,0,0, 0,0,  1,0,1, 0,hs(65536)));

        // reset state
        #12;
        chk("rst_u0_valid", 17'(ov0), 17'd0);
        chk("rst_u0_sop", 17'(os0), 17'd0);
        chk("rst_u0_re", ore0, 17'd0);
        chk("rst_u0_im", oim0, 17'd0);
        chk("rst_u1_valid", 17'(ov1), 17'd0);
        chk("rst_u1_re", ore1, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // asynchronous reset between clock edges
        @(negedge clk);
        vld0 = 0; vld1 = 0; sop0 = 0; sop1 = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_u0_re", ore0, 17'd0);
        chk("arst_u1_im", oim1, 17'd0);
        chk("arst_u1_valid", 17'(ov1), 17'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first input after reset is c=0 and priming restarts
        apply(mk(0,1,0,0, 5,0, 0,0,0, 0,0), 100);
        apply(mk(0,1,0,0, 6,0, 0,0,0, 0,0), 101);
        apply(mk(0,1,0,0, 7,0, 1,1,1, hs(12),0), 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
